bet_spin_ctrl: RTL and testbench
================================

Name: bet_spin_ctrl

Overview:
Front-end controller for the roulette game, driving the bet/spin side of the register-file interface. It collects up to 12 player bets over a valid/ready byte stream and presents them on bet1..bet12. On a spin request it asserts spin_check, waits a programmable settle time, samples the winning number from led_number, and reports a per-bet hit mask. It sits between the button/switch input logic and the regfile's bet and led_number ports.

Parameters:
SETTLE_CYCLES, 16, clock cycles spin_check is held high before led_number is sampled; legal range 1..65535.
MAX_NUMBER, 36, highest legal wheel number; a sampled led_number above this is an error.

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
bet_valid  input  1  a bet byte is offered on bet_data
bet_data  input  6  requested bet number
bet_ready  output  1  controller accepts a bet this cycle
spin_req  input  1  request a spin; level-sampled
clear  input  1  discard all bets and results, return to IDLE
spin_check  output  1  spin in progress, to regfile
led_number  input  6  winning number from regfile
bet1..bet12  output  8 each  stored bets: bit7 = occupied, bit6 = 0, [5:0] = number
bet_count  output  4  number of stored bets, 0..12
win_number  output  6  latched winning number
win_valid  output  1  win_number and hit_mask are valid
hit_mask  output  12  bit i-1 set when bet i is occupied and equals win_number
error  output  1  sampled led_number exceeded MAX_NUMBER
state_out  output  2  IDLE=0, SPIN=1, RESULT=2, ERROR=3

Behaviour:
- Reset: state IDLE. bet1..bet12=0, bet_count=0, spin_check=0, win_number=0, win_valid=0, hit_mask=0, error=0. bet_ready=1 after reset releases.
- IDLE state:
  - bet_ready = (bet_count < 12) and bet_data <= MAX_NUMBER. This is combinational on bet_data.
  - A transfer happens when bet_valid && bet_ready at a rising edge. bet[bet_count+1] <= {1'b1, 1'b0, bet_data} and bet_count increments. Bets fill bet1 first, in order.
  - A bet_data value above MAX_NUMBER is never accepted. bet_ready stays low, and the source must withdraw or change the value.
  - When bet_count = 12, bet_ready = 0 and further offers stall.
- IDLE -> SPIN: on spin_req=1 with bet_count >= 1. spin_req with bet_count = 0 is ignored.
  - If spin_req and a valid bet transfer occur in the same cycle, the bet is stored first and the spin then starts with the updated count.
- SPIN state:
  - spin_check = 1 and bet_ready = 0.
  - A down-counter loads SETTLE_CYCLES-1 on entry, so spin_check is high for exactly SETTLE_CYCLES cycles.
  - On the edge where the counter is 0, led_number is sampled.
  - If the sample is <= MAX_NUMBER: go to RESULT, latch win_number, and compute and register hit_mask. win_valid rises on the same edge.
  - Otherwise: go to ERROR with error = 1.
  - spin_check drops on that same edge.
- RESULT state: win_valid, win_number, hit_mask and the bets are held. spin_req is ignored.
- ERROR state: error = 1 and spin_check = 0. spin_req restarts SPIN with the bets kept and error cleared on entry.
- clear:
  - From any state, the next edge returns to IDLE with all bets, bet_count, win_*, hit_mask and error zeroed.
  - clear takes priority over spin_req and over a bet transfer in the same cycle.
  - clear during SPIN aborts the spin, and spin_check is 0 on the next cycle.
- Reset mid-operation has the same effect as clear and takes priority over it.
- Duplicate bet numbers are allowed, and each matching bet sets its own hit bit.
- hit_mask bits above bet_count are always 0.

Test Plan:
- Reset, then offer bets 7, 0, 36 (one per cycle, bet_valid held) -> bet1=0x87, bet2=0x80, bet3=0xA4, bet_count=3, bet_ready stays 1.
- Offer 13 bets of value 5 back-to-back -> first 12 accepted, bet12=0x85, bet_ready=0 from the edge where bet_count becomes 12, 13th held off.
- Bets 17, 4, 17, then spin_req with led_number=17 and SETTLE_CYCLES=16 -> spin_check high exactly 16 cycles, then win_valid=1, win_number=17, hit_mask=12'b000000000101.
- Spin with led_number=40 -> error=1, state_out=3. Set led_number=0 and pulse spin_req -> new SPIN, then RESULT with win_number=0 and hit_mask=0.
- Assert clear 5 cycles into SPIN -> spin_check=0 next cycle, bet_count=0, all bets 0, state_out=0.
- spin_req with no bets -> stays IDLE, spin_check never rises. Offer bet_data=37 -> bet_ready=0 and nothing stored.

Source files
------------

// File: rtl/bet_spin_ctrl.sv
// Bet/spin front end for the roulette game: collects up to 12 bets over a
// valid/ready byte stream, runs a timed spin, then samples and scores the
// winning number.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | accepting bets; a spin request with at least one bet starts a spin
// SPIN   | spin_check high; settle timer counting down to the sample point
// RESULT | win_number/hit_mask valid and held until clear
// ERROR  | sampled number out of range; a spin request retries with bets kept
module bet_spin_ctrl #(
   parameter int SETTLE_CYCLES = 16,
   parameter int MAX_NUMBER    = 36
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        bet_valid,
   input  logic [5:0]  bet_data,
   output logic        bet_ready,
   input  logic        spin_req,
   input  logic        clear,
   output logic        spin_check,
   input  logic [5:0]  led_number,
   output logic [7:0]  bet1,
   output logic [7:0]  bet2,
   output logic [7:0]  bet3,
   output logic [7:0]  bet4,
   output logic [7:0]  bet5,
   output logic [7:0]  bet6,
   output logic [7:0]  bet7,
   output logic [7:0]  bet8,
   output logic [7:0]  bet9,
   output logic [7:0]  bet10,
   output logic [7:0]  bet11,
   output logic [7:0]  bet12,
   output logic [3:0]  bet_count,
   output logic [5:0]  win_number,
   output logic        win_valid,
   output logic [11:0] hit_mask,
   output logic        error,
   output logic [1:0]  state_out
);

   localparam logic [5:0]  MAX_NUM   = 6'(MAX_NUMBER);
   localparam logic [15:0] TIMER_LD  = 16'(SETTLE_CYCLES - 1);
   localparam logic [3:0]  NUM_SLOTS = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SPIN   = 2'd1,
      ST_RESULT = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  bet_q [12];
   logic [3:0]  count_q;
   logic [15:0] timer_q;
   logic [5:0]  win_q;
   logic        win_valid_q;
   logic [11:0] hit_q;
   logic        error_q;

   logic        accept;
   logic        spin_done;
   logic        sample_ok;
   logic        enter_spin;
   logic [11:0] hit_d;

   assign bet_ready  = (state_q == ST_IDLE) && (count_q < NUM_SLOTS) && (bet_data <= MAX_NUM);
   assign accept     = bet_valid && bet_ready;
   assign spin_done  = (state_q == ST_SPIN) && (timer_q == 16'd0);
   assign sample_ok  = (led_number <= MAX_NUM);
   assign enter_spin = (state_d == ST_SPIN) && (state_q != ST_SPIN);

   // Next-state selection; clear overrides every other request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (spin_req && ((count_q != 4'd0) || accept)) state_d = ST_SPIN;
         ST_SPIN:   if (spin_done) state_d = sample_ok ? ST_RESULT : ST_ERROR;
         ST_RESULT: state_d = ST_RESULT;
         ST_ERROR:  if (spin_req) state_d = ST_SPIN;
         default:   state_d = ST_IDLE;
      endcase
      if (clear) state_d = ST_IDLE;
   end

   // Score every occupied slot against the number being sampled.
   always_comb begin
      hit_d = '0;
      for (int i = 0; i < 12; i++) begin
         hit_d[i] = bet_q[i][7] && (bet_q[i][5:0] == led_number);
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Bet storage, settle timer and result capture.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         for (int i = 0; i < 12; i++) bet_q[i] <= 8'd0;
         count_q     <= 4'd0;
         timer_q     <= 16'd0;
         win_q       <= 6'd0;
         win_valid_q <= 1'b0;
         hit_q       <= 12'd0;
         error_q     <= 1'b0;
      end else begin
         if (accept) begin
            for (int i = 0; i < 12; i++) begin
               if (count_q == 4'(i)) bet_q[i] <= {2'b10, bet_data};
            end
            count_q <= count_q + 4'd1;
         end
         if (enter_spin) begin
            timer_q <= TIMER_LD;
            error_q <= 1'b0;
         end else if ((state_q == ST_SPIN) && (timer_q != 16'd0)) begin
            timer_q <= timer_q - 16'd1;
         end
         if (spin_done && !clear) begin
            if (sample_ok) begin
               win_q       <= led_number;
               win_valid_q <= 1'b1;
               hit_q       <= hit_d;
            end else begin
               error_q <= 1'b1;
            end
         end
      end
   end

   assign spin_check = (state_q == ST_SPIN);
   assign bet1       = bet_q[0];
   assign bet2       = bet_q[1];
   assign bet3       = bet_q[2];
   assign bet4       = bet_q[3];
   assign bet5       = bet_q[4];
   assign bet6       = bet_q[5];
   assign bet7       = bet_q[6];
   assign bet8       = bet_q[7];
   assign bet9       = bet_q[8];
   assign bet10      = bet_q[9];
   assign bet11      = bet_q[10];
   assign bet12      = bet_q[11];
   assign bet_count  = count_q;
   assign win_number = win_q;
   assign win_valid  = win_valid_q;
   assign hit_mask   = hit_q;
   assign error      = error_q;
   assign state_out  = state_q;

endmodule

// File: tb/tb_bet_spin_ctrl.sv
// Bench for bet_spin_ctrl: fixed vectors, directed multi-cycle sequences and
// random traffic, all checked against a queue-based game model.
module tb_bet_spin_ctrl;

   localparam int SETTLE = 16;
   localparam int MAXN   = 36;

   logic        clock = 1'b0;
   logic        reset, bet_valid, spin_req, clear;
   logic [5:0]  bet_data, led_number;
   logic        bet_ready, spin_check, win_valid, error;
   logic [7:0]  bet1, bet2, bet3, bet4, bet5, bet6, bet7, bet8, bet9, bet10, bet11, bet12;
   logic [3:0]  bet_count;
   logic [5:0]  win_number;
   logic [11:0] hit_mask;
   logic [1:0]  state_out;
   logic [7:0]  bets_dut [12];

   int total = 0;
   int bad   = 0;

   // Game model: bets as a queue, phase uses the documented state_out codes.
   int          m_bets[$];
   int          m_phase;
   int          m_spin_left;
   int          m_win;
   bit          m_wv;
   bit [11:0]   m_hit;
   bit          m_err;

   bet_spin_ctrl #(.SETTLE_CYCLES(SETTLE), .MAX_NUMBER(MAXN)) dut (
      .clock(clock), .reset(reset), .bet_valid(bet_valid), .bet_data(bet_data),
      .bet_ready(bet_ready), .spin_req(spin_req), .clear(clear),
      .spin_check(spin_check), .led_number(led_number),
      .bet1(bet1), .bet2(bet2), .bet3(bet3), .bet4(bet4), .bet5(bet5), .bet6(bet6),
      .bet7(bet7), .bet8(bet8), .bet9(bet9), .bet10(bet10), .bet11(bet11), .bet12(bet12),
      .bet_count(bet_count), .win_number(win_number), .win_valid(win_valid),
      .hit_mask(hit_mask), .error(error), .state_out(state_out)
   );

   always #5 clock = ~clock;

   always_comb begin
      bets_dut[0] = bet1;  bets_dut[1] = bet2;   bets_dut[2]  = bet3;  bets_dut[3]  = bet4;
      bets_dut[4] = bet5;  bets_dut[5] = bet6;   bets_dut[6]  = bet7;  bets_dut[7]  = bet8;
      bets_dut[8] = bet9;  bets_dut[9] = bet10;  bets_dut[10] = bet11; bets_dut[11] = bet12;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_clear();
      m_bets.delete();
      m_phase = 0; m_spin_left = 0; m_win = 0; m_wv = 0; m_hit = '0; m_err = 0;
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_step();
      if (reset || clear) begin
         model_clear();
         return;
      end
      case (m_phase)
         0: begin
            if (bet_valid && m_bets.size() < 12 && int'(bet_data) <= MAXN)
               m_bets.push_back(int'(bet_data));
            if (spin_req && m_bets.size() >= 1) begin
               m_phase = 1; m_spin_left = SETTLE;
            end
         end
         1: begin
            m_spin_left--;
            if (m_spin_left == 0) begin
               if (int'(led_number) <= MAXN) begin
                  m_phase = 2; m_win = int'(led_number); m_wv = 1; m_hit = '0;
                  foreach (m_bets[i]) if (m_bets[i] == m_win) m_hit[i] = 1'b1;
               end else begin
                  m_phase = 3; m_err = 1;
               end
            end
         end
         3: begin
            if (spin_req) begin
               m_phase = 1; m_spin_left = SETTLE; m_err = 0;
            end
         end
         default: ;
      endcase
   endtask

   task automatic check_all();
      bit exp_ready;
      exp_ready = (m_phase == 0) && (m_bets.size() < 12) && (int'(bet_data) <= MAXN);
      chk("state_out", 32'(state_out), 32'(m_phase));
      chk("bet_count", 32'(bet_count), 32'(m_bets.size()));
      chk("bet_ready", 32'(bet_ready), 32'(exp_ready));
      chk("spin_check", 32'(spin_check), 32'(m_phase == 1));
      chk("win_valid", 32'(win_valid), 32'(m_wv));
      chk("win_number", 32'(win_number), 32'(m_win));
      chk("hit_mask", 32'(hit_mask), 32'(m_hit));
      chk("error", 32'(error), 32'(m_err));
      for (int i = 0; i < 12; i++) begin
         logic [7:0] eb;
         eb = (i < m_bets.size()) ? (8'h80 | 8'(m_bets[i])) : 8'h00;
         chk($sformatf("bet%0d", i + 1), 32'(bets_dut[i]), 32'(eb));
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      reset = 0; bet_valid = 0; bet_data = 6'd0; spin_req = 0; clear = 0;
   endtask

   task automatic do_clear();
      idle_inputs(); clear = 1; tick(); clear = 0;
   endtask

   task automatic offer(input int v);
      bet_valid = 1; bet_data = 6'(v); tick(); bet_valid = 0; bet_data = 6'd0;
   endtask

   task automatic wait_state(input int s, input string nm);
      int n = 0;
      while (state_out !== 2'(s) && n < 200) begin
         tick(); n++;
      end
      chk(nm, 32'(state_out), 32'(s));
   endtask

   typedef struct {
      bit       v;
      int       d;
      bit       sp;
      bit       cl;
      bit       ex_ready;
      int       ex_count;
      int       ex_state;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int n;
      // inputs v, data, spin, clear; expected after the edge: ready, count, state
      vecs[0] = '{1, 7,  0, 0, 1, 1, 0};
      vecs[1] = '{1, 0,  0, 0, 1, 2, 0};
      vecs[2] = '{1, 36, 0, 0, 1, 3, 0};
      vecs[3] = '{1, 37, 0, 0, 0, 3, 0};
      vecs[4] = '{0, 5,  1, 0, 0, 3, 1};
      vecs[5] = '{0, 5,  0, 1, 1, 0, 0};
      vecs[6] = '{0, 5,  1, 0, 1, 0, 0};
      vecs[7] = '{1, 9,  1, 0, 0, 1, 1};
      vecs[8] = '{1, 9,  1, 1, 1, 0, 0};

      idle_inputs(); led_number = 6'd0; reset = 1;
      model_clear();
      tick(); tick();
      reset = 0;
      #1;
      check_all();

      // Table vectors.
      foreach (vecs[k]) begin
         bet_valid = vecs[k].v; bet_data = 6'(vecs[k].d);
         spin_req = vecs[k].sp; clear = vecs[k].cl;
         tick();
         chk($sformatf("vec%0d ready", k), 32'(bet_ready), 32'(vecs[k].ex_ready));
         chk($sformatf("vec%0d count", k), 32'(bet_count), 32'(vecs[k].ex_count));
         chk($sformatf("vec%0d state", k), 32'(state_out), 32'(vecs[k].ex_state));
      end
      idle_inputs(); tick();

      // Bets 7, 0, 36 with bet_valid held.
      do_clear();
      bet_valid = 1;
      bet_data = 6'd7;  tick();
      bet_data = 6'd0;  tick();
      bet_data = 6'd36; tick();
      chk("seqA bet_ready", 32'(bet_ready), 32'd1);
      bet_valid = 0;
      chk("seqA bet1", 32'(bet1), 32'h87);
      chk("seqA bet2", 32'(bet2), 32'h80);
      chk("seqA bet3", 32'(bet3), 32'hA4);
      chk("seqA count", 32'(bet_count), 32'd3);

      // 13 back-to-back offers of 5.
      do_clear();
      bet_valid = 1; bet_data = 6'd5;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (i == 11) chk("seqB ready at 12", 32'(bet_ready), 32'd0);
      end
      chk("seqB count", 32'(bet_count), 32'd12);
      chk("seqB bet12", 32'(bet12), 32'h85);
      bet_valid = 0;

      // Score bets 17, 4, 17 against 17.
      do_clear();
      offer(17); offer(4); offer(17);
      led_number = 6'd17; spin_req = 1; tick(); spin_req = 0;
      n = 0;
      while (spin_check === 1'b1 && n < 100) begin
         n++; tick();
      end
      chk("seqC spin cycles", 32'(n), 32'(SETTLE));
      chk("seqC win_valid", 32'(win_valid), 32'd1);
      chk("seqC win_number", 32'(win_number), 32'd17);
      chk("seqC hit_mask", 32'(hit_mask), 32'b000000000101);
      spin_req = 1; tick(); tick(); spin_req = 0;
      chk("seqC result holds", 32'(state_out), 32'd2);

      // Out-of-range sample then retry.
      do_clear();
      offer(3);
      led_number = 6'd40; spin_req = 1; tick(); spin_req = 0;
      wait_state(3, "seqD error state");
      chk("seqD error", 32'(error), 32'd1);
      chk("seqD spin_check", 32'(spin_check), 32'd0);
      led_number = 6'd0; spin_req = 1; tick(); spin_req = 0;
      chk("seqD retry spin", 32'(spin_check), 32'd1);
      chk("seqD error cleared", 32'(error), 32'd0);
      chk("seqD bets kept", 32'(bet1), 32'h83);
      wait_state(2, "seqD result state");
      chk("seqD win_number", 32'(win_number), 32'd0);
      chk("seqD hit_mask", 32'(hit_mask), 32'd0);
      chk("seqD win_valid", 32'(win_valid), 32'd1);

      // Abort a spin with clear.
      do_clear();
      offer(1); offer(2);
      led_number = 6'd1; spin_req = 1; tick(); spin_req = 0;
      repeat (5) tick();
      clear = 1; tick(); clear = 0;
      chk("seqE spin_check", 32'(spin_check), 32'd0);
      chk("seqE count", 32'(bet_count), 32'd0);
      chk("seqE bet1", 32'(bet1), 32'd0);
      chk("seqE state", 32'(state_out), 32'd0);

      // Spin with no bets, then an out-of-range offer.
      do_clear();
      n = 0;
      spin_req = 1;
      repeat (4) begin
         tick();
         if (spin_check) n++;
      end
      spin_req = 0;
      chk("seqF no spin", 32'(n), 32'd0);
      bet_valid = 1; bet_data = 6'd37; #1;
      chk("seqF ready 37", 32'(bet_ready), 32'd0);
      tick(); bet_valid = 0;
      chk("seqF nothing stored", 32'(bet_count), 32'd0);

      // Random traffic against the model.
      do_clear();
      for (int c = 0; c < 4000; c++) begin
         bet_valid  = ($urandom_range(0, 1) == 1);
         bet_data   = 6'($urandom_range(0, 40));
         spin_req   = ($urandom_range(0, 7) == 0);
         clear      = ($urandom_range(0, 149) == 0);
         reset      = ($urandom_range(0, 399) == 0);
         led_number = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(37, 63))
                                                  : 6'($urandom_range(0, 36));
         tick();
      end
      idle_inputs(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
